alu_exec_unit: RTL and testbench

//  Datapath ALU that executes the 4-bit ALUCtrl codes produced by the ALU control decoder.

---
 rtl/alu_exec_unit.sv | 195 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logic/compare/shift ops, iterative unsigned mult (shift-add) and div (restoring).
// Define ALU_FAST_MUL_EN to make mult a single-cycle combinational multiply.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

    localparam int CNT_W = $clog2(WIDTH);
    localparam int SH_W  = (WIDTH < 5) ? WIDTH : 5;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 op_div_q, op_div_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 zero_q, zero_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [SH_W-1:0]         shamt;
    logic [WIDTH-1:0]        sc_res, sc_hi;
    logic                    sc_err, is_iter_op;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   step;

`ifdef ALU_FAST_MUL_EN
    logic [2*WIDTH-1:0]   prod_full;
    assign prod_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        sc_res     = '0;
        sc_hi      = '0;
        sc_err     = 1'b0;
        is_iter_op = 1'b0;
        case (alu_ctrl)
            4'd0:  sc_res = a & b;
            4'd1:  sc_res = a | b;
            4'd2:  sc_res = a + b;
            4'd3:  sc_res = a - b;
            4'd4:  sc_res = {{(WIDTH-1){1'b0}}, (a_s <  b_s)};
            4'd5:  sc_res = {{(WIDTH-1){1'b0}}, (a_s >  b_s)};
            4'd6:  sc_res = ~a;
            4'd7: begin
`ifdef ALU_FAST_MUL_EN
                sc_res = prod_full[WIDTH-1:0];
                sc_hi  = prod_full[2*WIDTH-1:WIDTH];
`else
                is_iter_op = 1'b1;
`endif
            end
            4'd8: begin
                // Divide-by-zero short-circuits to a fixed answer instead of iterating
                if (b == '0) begin
                    sc_res = '1;
                    sc_hi  = a;
                    sc_err = 1'b1;
                end else begin
                    is_iter_op = 1'b1;
                end
            end
            4'd9:  sc_res = a << shamt;
            4'd10: sc_res = a >> shamt;
            4'd11: sc_res = {{(WIDTH-1){1'b0}}, (a_s <= b_s)};
            4'd12: sc_res = {{(WIDTH-1){1'b0}}, (a_s >= b_s)};
            4'd13: sc_res = {{(WIDTH-1){1'b0}}, (a == b)};
            4'd14: sc_res = {{(WIDTH-1){1'b0}}, (a != b)};
            default: sc_err = 1'b1;
        endcase
    end

    // acc holds {partial product high, multiplier} for mult and {remainder, dividend/quotient} for div
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
        if (!op_div_q)
            step = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_trial[WIDTH+1])
            step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else
            step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_div_d = op_div_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_iter_op) begin
                        op_div_d = (alu_ctrl == 4'd8);
                        acc_d    = {{WIDTH{1'b0}}, (alu_ctrl == 4'd8) ? a : b};
                        opnd_d   = (alu_ctrl == 4'd8) ? b : a;
                        count_d  = CNT_W'(WIDTH - 1);
                        busy_d   = 1'b1;
                        state_d  = ITER;
                    end else begin
                        result_d = sc_res;
                        hi_d     = sc_hi;
                        zero_d   = (sc_res == '0);
                        err_d    = sc_err;
                        done_d   = 1'b1;
                    end
                end
            end
            ITER: begin
                acc_d   = step;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1))
                    state_d = FIN;
            end
            FIN: begin
                // The final bit is processed here so done lands WIDTH+1 cycles after start
                result_d = step[WIDTH-1:0];
                hi_d     = step[2*WIDTH-1:WIDTH];
                zero_d   = (step[WIDTH-1:0] == '0);
                err_d    = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            op_div_q <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_div_q <= op_div_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        opnd_q <= opnd_d;
    end

    assign result = result_q;
    assign hi     = hi_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32); honours ALU_FAST_MUL_EN for mult timing.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] a, b;
    logic [W-1:0] result, hi;
    logic         zero, busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctrl(alu_ctrl),
        .a(a), .b(b), .result(result), .hi(hi), .zero(zero),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

`ifdef ALU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one op at a negedge, scramble inputs afterwards, wait (bounded) for done.
    task automatic do_op(input logic [3:0] c, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output int lat, output int busy_cycles);
        @(negedge clk);
        alu_ctrl = c; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; alu_ctrl = 4'd2; a = 32'hDEAD_BEEF; b = 32'h0;
        lat = 1; busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int lat, bc, ndone;

    initial begin
        rst_n = 1'b0; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_hi", hi, 0);
        chk("rst_flags", {zero, busy, done, err}, 4'b0000);
        rst_n = 1'b1;

        do_op(4'd2, 5, 3, lat, bc);
        chk("add_lat", lat, 1);
        chk("add_res", result, 8);
        chk("add_flags", {zero, busy, err}, 3'b000);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("hold_res", result, 8);

        do_op(4'd4, 32'hFFFF_FFFF, 1, lat, bc);  chk("slt_neg", result, 1);
        do_op(4'd12, 32'hFFFF_FFFF, 1, lat, bc); chk("sget_neg", result, 0);
        do_op(4'd3, 7, 7, lat, bc);
        chk("sub_zero_res", result, 0);
        chk("sub_zero_flag", zero, 1);
        do_op(4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, lat, bc); chk("and", result, 32'h00F0_1200);
        do_op(4'd1, 32'hF000_0001, 32'h0000_0F00, lat, bc); chk("or", result, 32'hF000_0F01);
        do_op(4'd5, 5, 32'hFFFF_FFFD, lat, bc);  chk("sgt", result, 1);
        do_op(4'd6, 0, 0, lat, bc);              chk("not", result, 32'hFFFF_FFFF);
        do_op(4'd9, 1, 31, lat, bc);             chk("sll31", result, 32'h8000_0000);
        do_op(4'd9, 3, 33, lat, bc);             chk("sll_b40", result, 6);
        do_op(4'd10, 32'h8000_0000, 31, lat, bc); chk("srl31", result, 1);
        do_op(4'd11, 32'hFFFF_FFFB, 32'hFFFF_FFFB, lat, bc); chk("slet_eq", result, 1);
        do_op(4'd13, 7, 7, lat, bc);             chk("set", result, 1);
        do_op(4'd14, 7, 7, lat, bc);             chk("sdt", {result, zero}, 33'h1);
        do_op(4'd2, 32'hFFFF_FFFF, 1, lat, bc);  chk("add_wrap", {result, zero, err}, 34'h2);

        do_op(4'd15, 5, 5, lat, bc);
        chk("inv_lat", lat, 1);
        chk("inv_res", {result, hi}, 64'h0);
        chk("inv_flags", {zero, err}, 2'b11);

        do_op(4'd7, 32'hFFFF_FFFF, 2, lat, bc);
        chk("mul_lat", lat, MUL_LAT);
        chk("mul_busy", bc, MUL_LAT - 1);
        chk("mul_res", {hi, result}, {32'h1, 32'hFFFF_FFFE});
        chk("mul_err", err, 0);

        do_op(4'd7, 32'h1234_5678, 32'h9ABC_DEF0, lat, bc);
        chk("mul2_res", {hi, result}, 64'h0B00_EA4E_242D_2080);

        do_op(4'd8, 100, 7, lat, bc);
        chk("div_lat", lat, W + 1);
        chk("div_busy", bc, W);
        chk("div_res", {result, hi}, {32'd14, 32'd2});
        chk("div_err", err, 0);

        do_op(4'd8, 9, 0, lat, bc);
        chk("div0_lat", lat, 1);
        chk("div0_res", {result, hi}, {32'hFFFF_FFFF, 32'd9});
        chk("div0_err", err, 1);

        // start during a div is dropped; exactly one done must appear
        @(negedge clk);
        alu_ctrl = 4'd8; a = 32'hFFFF_FFFF; b = 32'h10; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        alu_ctrl = 4'd2; a = 1; b = 1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("mid_div_ndone", ndone, 1);
        chk("mid_div_res", {result, hi}, {32'h0FFF_FFFF, 32'hF});

        // back-to-back start in the done cycle
        do_op(4'd2, 10, 20, lat, bc);
        alu_ctrl = 4'd3; a = 10; b = 4; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("b2b_done", done, 1);
        chk("b2b_res", result, 6);

        // reset in the middle of an iterative mult
        @(negedge clk);
        alu_ctrl = 4'd7; a = 32'hFFFF_FFFF; b = 2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_res", {result, hi}, 64'h0);
        chk("rst_mid_done", done, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("rst_mid_nodone", ndone, 0);
        do_op(4'd2, 2, 2, lat, bc);
        chk("post_rst_lat", lat, 1);
        chk("post_rst_res", result, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
